// File: rtl/noc_pkt_injector.sv
// Packet source for one router input port: bursts of wormhole packets spread round-robin over VCs.
// Optional stall timeout is built only when PKT_INJ_TIMEOUT_EN is defined.
package noc_params;
  localparam int MESH_SIZE_X       = 4;
  localparam int MESH_SIZE_Y       = 4;
  localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module noc_pkt_injector #(
  parameter int unsigned VC_NUM         = noc_params::VC_NUM,
  parameter int unsigned MAX_PKT_SIZE   = 16,
  parameter int unsigned GAP_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [15:0]                           pkt_num_i,
  input  logic [$clog2(MAX_PKT_SIZE+1)-1:0]     pkt_size_i,
  input  logic [GAP_WIDTH-1:0]                  gap_i,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  logic [VC_NUM-1:0]                     vc_mask_i,
  input  logic [VC_NUM-1:0]                     on_off_i,
  output noc_params::flit_t                     data_o,
  output logic                                  valid_flit_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [1:0]                            error_o,
  output logic [31:0]                           flit_cnt_o
);
  localparam int unsigned SZ_W  = $clog2(MAX_PKT_SIZE + 1);
  localparam int unsigned VC_W  = noc_params::VC_SIZE;
  localparam int unsigned SEQ_W = noc_params::FLIT_DATA_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                                  state_q, state_d;
  logic [SZ_W-1:0]                         size_q, size_d, flit_idx_q, flit_idx_d;
  logic [15:0]                             num_q, num_d, pkt_idx_q, pkt_idx_d;
  logic [GAP_WIDTH-1:0]                    gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
  logic [VC_NUM-1:0]                       mask_q, mask_d;
  logic [VC_W-1:0]                         rr_q, rr_d, cur_vc_q, cur_vc_d;
  logic [SEQ_W-1:0]                        seq_q, seq_d;
  noc_params::flit_t                       data_q, data_d;
  logic                                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]                              err_q, err_d;
  logic [31:0]                             flit_cnt_q, flit_cnt_d;
`ifdef PKT_INJ_TIMEOUT_EN
  localparam int unsigned ST_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [ST_W-1:0]                         stall_q, stall_d;
`endif

  logic [VC_W-1:0] sel_vc, cur_vc;
  logic            sel_found, illegal, last_flit, last_pkt;
  int unsigned     idx;

  // First eligible VC at or after the RR pointer; only consulted on a packet's first flit.
  always_comb begin
    sel_vc    = rr_q;
    sel_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      idx = (i + 32'(rr_q)) % VC_NUM;
      if (!sel_found && mask_q[VC_W'(idx)]) begin
        sel_vc    = VC_W'(idx);
        sel_found = 1'b1;
      end
    end
  end

  assign cur_vc    = (flit_idx_q == '0) ? sel_vc : cur_vc_q;
  assign last_flit = (flit_idx_q == size_q - SZ_W'(1));
  assign last_pkt  = (pkt_idx_q == num_q - 16'd1);
  assign illegal   = (pkt_size_i == '0) || (pkt_size_i > SZ_W'(MAX_PKT_SIZE)) ||
                     (pkt_num_i == '0) || (vc_mask_i == '0);

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    num_d      = num_q;
    gap_d      = gap_q;
    x_d        = x_q;
    y_d        = y_q;
    mask_d     = mask_q;
    rr_d       = rr_q;
    cur_vc_d   = cur_vc_q;
    flit_idx_d = flit_idx_q;
    pkt_idx_d  = pkt_idx_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    flit_cnt_d = flit_cnt_q;
`ifdef PKT_INJ_TIMEOUT_EN
    stall_d    = stall_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_d     = pkt_size_i;
          num_d      = pkt_num_i;
          gap_d      = gap_i;
          x_d        = x_dest_i;
          y_d        = y_dest_i;
          mask_d     = vc_mask_i;
          flit_idx_d = '0;
          pkt_idx_d  = '0;
          gap_cnt_d  = '0;
          seq_d      = '0;
          err_d      = {1'b0, illegal};
`ifdef PKT_INJ_TIMEOUT_EN
          stall_d    = '0;
`endif
          // Illegal config pulses done right away so it lands the cycle after start.
          if (illegal) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEND;
            busy_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (on_off_i[cur_vc]) begin
          valid_d          = 1'b1;
          flit_cnt_d       = flit_cnt_q + 32'd1;
          seq_d            = seq_q + SEQ_W'(1);
          data_d           = '0;
          data_d.vc_id     = cur_vc;
`ifdef PKT_INJ_TIMEOUT_EN
          stall_d          = '0;
`endif
          if (size_q == SZ_W'(1))   data_d.flit_label = noc_params::HEADTAIL;
          else if (flit_idx_q == '0) data_d.flit_label = noc_params::HEAD;
          else if (last_flit)        data_d.flit_label = noc_params::TAIL;
          else                       data_d.flit_label = noc_params::BODY;
          if (flit_idx_q == '0) begin
            data_d.data.head_data.x_dest  = x_q;
            data_d.data.head_data.y_dest  = y_q;
            data_d.data.head_data.head_pl = seq_q[noc_params::HEAD_PAYLOAD_SIZE-1:0];
            cur_vc_d = sel_vc;
            rr_d     = VC_W'((32'(sel_vc) + 32'd1) % VC_NUM);
          end else begin
            data_d.data.bt_pl = seq_q;
          end
          if (last_flit) begin
            flit_idx_d = '0;
            pkt_idx_d  = pkt_idx_q + 16'd1;
          end else begin
            flit_idx_d = flit_idx_q + SZ_W'(1);
          end
          if (last_flit && last_pkt) state_d = S_DONE;
          else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end
        end
`ifdef PKT_INJ_TIMEOUT_EN
        else begin
          stall_d = stall_q + ST_W'(1);
          if (stall_q + ST_W'(1) == ST_W'(TIMEOUT_CYCLES)) begin
            err_d[1] = 1'b1;
            state_d  = S_DONE;
          end
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) state_d = S_SEND;
        else gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      S_DONE: begin
        // done_q already high means the pulse was issued on entry (illegal config).
        done_d  = !done_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      num_q      <= '0;
      gap_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mask_q     <= '0;
      rr_q       <= '0;
      cur_vc_q   <= '0;
      flit_idx_q <= '0;
      pkt_idx_q  <= '0;
      gap_cnt_q  <= '0;
      seq_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      flit_cnt_q <= '0;
`ifdef PKT_INJ_TIMEOUT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mask_q     <= mask_d;
      rr_q       <= rr_d;
      cur_vc_q   <= cur_vc_d;
      flit_idx_q <= flit_idx_d;
      pkt_idx_q  <= pkt_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_q      <= seq_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flit_cnt_q <= flit_cnt_d;
`ifdef PKT_INJ_TIMEOUT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign flit_cnt_o   = flit_cnt_q;
endmodule

// File: doc/noc_pkt_injector.md
# noc_pkt_injector

Synthesizable, parametrised packet source for one router input port. Generates a burst of wormhole packets (HEAD/BODY/TAIL or HEADTAIL `flit_t` from `noc_params`), spreads packets round-robin over a configurable set of VCs, honours per-VC on/off flow control and inserts a programmable inter-flit gap. It drives `data_i`/`valid_flit_i` of one `input_block` port and serves as the stimulus engine for router and mesh-level benches.

## Interface
- `VC_NUM`, `noc_params::VC_NUM`, number of virtual channels.
- `MAX_PKT_SIZE`, 16, largest legal packet length in flits.
- `GAP_WIDTH`, 4, width of the inter-flit gap setting.
- `TIMEOUT_CYCLES`, 256, stall limit; used only with `PKT_INJ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  burst start; sampled only in IDLE.
- `pkt_num_i`  in  16  number of packets in the burst.
- `pkt_size_i`  in  $clog2(MAX_PKT_SIZE+1)  flits per packet.
- `gap_i`  in  GAP_WIDTH  idle cycles after every flit.
- `x_dest_i`, `y_dest_i`  in  DEST_ADDR_SIZE_X/Y  head destination.
- `vc_mask_i`  in  VC_NUM  eligible VCs.
- `on_off_i`  in  VC_NUM  downstream on/off; 1 = flit may be sent on that VC.
- `data_o`  out  flit_t  flit to the router.
- `valid_flit_o`  out  1  `data_o` valid.
- `busy_o`  out  1  burst in progress.
- `done_o`  out  1  one-cycle pulse at burst end.
- `error_o`  out  2  bit0 illegal config, bit1 timeout.
- `flit_cnt_o`  out  32  flits sent since reset.

## Operation
- FSM: IDLE -> SEND -> GAP -> SEND ... -> DONE -> IDLE.
- IDLE: on `start_i`=1, latch every config input and go to SEND. Config is illegal if `pkt_size_i`=0, `pkt_size_i`>MAX_PKT_SIZE, `pkt_num_i`=0, or `vc_mask_i`=0. An illegal config goes to DONE, sets `error_o[0]`, and sends no flit.
- Packet start: the packet takes the first set bit of the latched mask at or after the RR pointer, wrapping around. The pointer then moves to the chosen VC+1 (mod VC_NUM). All flits of the packet carry that `vc_id`, and packets never interleave.
- SEND: a flit is issued on an edge where `on_off_i[cur_vc]`=1. Otherwise the block holds, with `valid_flit_o`=0 and no state change.
- Flit labels:
  - size 1: HEADTAIL.
  - Otherwise: flit 0 HEAD, last flit TAIL, the rest BODY.
- Head data: `x_dest`/`y_dest` from the latched config. Payload fields (`head_pl`, `bt_pl`) carry the burst flit sequence number. The sequence starts at 0 per burst and is zero-extended or truncated to the field width.
- After each flit: if gap>0, go to GAP for exactly gap cycles, then SEND. If gap=0, go straight to SEND.
- After the last flit of the last packet, go to DONE. `done_o`=1 for one cycle, then IDLE.
- `start_i` during a burst is ignored. `error_o` holds until the next accepted `start_i` or `rst`.
- `flit_cnt_o` increments per issued flit and wraps modulo 2^32. It is cleared only by `rst`.

## Timing
- Reset values: all outputs 0; `data_o` all zeros; FSM in IDLE; RR pointer 0; sequence counter 0.
- Reset asserted mid-burst aborts the burst on the next edge with the same values. No `done_o` is produced.
- All outputs are registered.
- With `start_i` sampled at edge N and the VC on, the first flit is valid in the cycle after edge N+1.
- `valid_flit_o` is high for exactly one cycle per flit. `data_o` holds its last value while valid is low.
- gap=0 with on/off held high gives one flit per cycle, back-to-back across packet boundaries.
- `busy_o`=1 from the edge after an accepted start until `done_o` asserts.
- `done_o` asserts the cycle after the final flit's valid cycle. Exception: an illegal config asserts `done_o` the cycle after start.
- A change of `on_off_i` takes effect on the same edge it is sampled.

## Configuration
- `PKT_INJ_TIMEOUT_EN` defined:
  - In SEND, a counter runs while `on_off_i[cur_vc]`=0.
  - When it reaches TIMEOUT_CYCLES, the burst aborts: `error_o[1]`=1, go to DONE, `done_o` pulses.
  - The counter clears whenever a flit is issued.
- Not defined: no counter is built, stalls last indefinitely, and `error_o[1]` is tied to 0.

## Test plan
- Config size=4, num=1, gap=0, mask=2'b01, on_off all 1, start -> HEAD, BODY, BODY, TAIL on 4 consecutive cycles, all vc_id 0, payload seq 0..3. `done_o` pulses the next cycle and `flit_cnt_o`=4.
- Config size=1, num=3, mask=2'b11 -> HEADTAIL on vc 0, 1, 0 in that order. `flit_cnt_o`=3.
- Config size=3, gap=2 -> consecutive valid flits are spaced exactly 3 cycles apart.
- Config size=4, on_off[0] dropped for 5 cycles after the HEAD -> no valid during the stall. BODY is issued on the first edge after on_off[0] returns. No flit appears on another VC meanwhile.
- Start with pkt_size=0 -> no valid flit, `error_o`=2'b01, `done_o` pulses one cycle after start. A start during a busy burst is ignored, and `rst` mid-burst returns all outputs to 0.
- With `PKT_INJ_TIMEOUT_EN` and TIMEOUT_CYCLES=8, on_off held 0 -> `error_o[1]`=1 and `done_o` after 8 stall cycles.
